// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline hazard controller: FSM states and
// ALU operand forward-select codes.
package mips_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_BR_FLUSH = 2'd2,
    HZ_FREEZE   = 2'd3
  } hz_state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX-stage forwarding compare: selects MEM result, WB data or the
// register file for each ALU operand.
module fwd_unit
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_reg_desti_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_reg_desti_i,
  output fwd_sel_t          fwd_a_o,
  output fwd_sel_t          fwd_b_o
);

  // MEM is younger than WB, so its result wins; $0 is hard-wired and never forwarded.
  function automatic fwd_sel_t sel_src(input logic [REG_AW-1:0] src);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (mem_reg_write_i && (mem_reg_desti_i != '0) && (mem_reg_desti_i == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write_i && (wb_reg_desti_i != '0) && (wb_reg_desti_i == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_o = sel_src(ex_rs_i);
    fwd_b_o = sel_src(ex_rt_i);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding, load-use stall,
// branch flush and req/ack freeze. Define HAZ_PERF_CNT_EN to add perf counters.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_MemRead,
  input  logic [REG_AW-1:0] ex_regDesti,
  input  logic              mem_regWrite,
  input  logic [REG_AW-1:0] mem_regDesti,
  input  logic              mem_PCSrc,
  input  logic              wb_regWrite,
  input  logic [REG_AW-1:0] wb_regDesti,
  input  logic              frz_req,
  output logic              frz_ack,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        hz_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  frz_cnt
`endif
);

  hz_state_e state_q, state_d;
  logic      frz_ack_q;
  logic      lu;

  fwd_unit #(
    .REG_AW (REG_AW)
  ) u_fwd_unit (
    .ex_rs_i         (ex_rs),
    .ex_rt_i         (ex_rt),
    .mem_reg_write_i (mem_regWrite),
    .mem_reg_desti_i (mem_regDesti),
    .wb_reg_write_i  (wb_regWrite),
    .wb_reg_desti_i  (wb_regDesti),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b)
  );

  assign lu = ex_MemRead && (ex_regDesti != '0) &&
              ((ex_regDesti == id_rs) || (id_uses_rt && (ex_regDesti == id_rt)));

  // Next state: branch beats load-use beats freeze; stall/flush last one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HZ_RUN: begin
        if (mem_PCSrc) begin
          state_d = HZ_BR_FLUSH;
        end else if (lu) begin
          state_d = HZ_LU_STALL;
        end else if (frz_req) begin
          state_d = HZ_FREEZE;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_LU_STALL, HZ_BR_FLUSH, HZ_FREEZE: begin
        state_d = frz_req ? HZ_FREEZE : HZ_RUN;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    unique case (state_q)
      HZ_RUN: begin
        if (mem_PCSrc) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (lu) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
      // Load-use is not re-evaluated here: the stalled load has already moved on.
      HZ_LU_STALL, HZ_BR_FLUSH: begin
        if (mem_PCSrc) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end
      end
      HZ_FREEZE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
      default: begin
        pc_write = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= HZ_RUN;
      frz_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frz_ack_q <= (state_d == HZ_FREEZE);
    end
  end

  assign frz_ack  = frz_ack_q;
  assign hz_state = state_q;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] frz_cnt_q,   frz_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    frz_cnt_d   = frz_cnt_q;
    if ((state_q == HZ_LU_STALL) && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if ((state_q == HZ_BR_FLUSH) && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
    if ((state_q == HZ_FREEZE) && (frz_cnt_q != CntMax)) begin
      frz_cnt_d = frz_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      frz_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      frz_cnt_q   <= frz_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign frz_cnt   = frz_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random
// traffic, checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              rst;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_desti;
    logic              mem_we;
    logic [REG_AW-1:0] mem_desti;
    logic              mem_pcsrc;
    logic              wb_we;
    logic [REG_AW-1:0] wb_desti;
    logic              frz_req;
  } stim_t;

  typedef struct packed {
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] hz_state;
    logic       frz_ack;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_regDesti, mem_regDesti, wb_regDesti;
  logic              id_uses_rt, ex_MemRead, mem_regWrite, mem_PCSrc, wb_regWrite, frz_req;
  logic              frz_ack, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]        fwd_a, fwd_b, hz_state;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Model state: mode 0 run, 1 load-use stall, 2 branch flush, 3 frozen.
  int   m_mode = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_AW (REG_AW),
    .CNT_W  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_MemRead   (ex_MemRead),
    .ex_regDesti  (ex_regDesti),
    .mem_regWrite (mem_regWrite),
    .mem_regDesti (mem_regDesti),
    .mem_PCSrc    (mem_PCSrc),
    .wb_regWrite  (wb_regWrite),
    .wb_regDesti  (wb_regDesti),
    .frz_req      (frz_req),
    .frz_ack      (frz_ack),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .hz_state     (hz_state)
  );

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [REG_AW-1:0] src);
    if (src == 0) return 2'b00;
    if (s.mem_we && s.mem_desti == src) return 2'b10;
    if (s.wb_we && s.wb_desti == src) return 2'b01;
    return 2'b00;
  endfunction

  // Compute this cycle's expected outputs, then advance the model by one edge.
  task automatic model_step(input stim_t s, output exp_t e);
    bit load_use;
    bit branch;
    load_use = s.ex_mem_read && s.ex_desti != 0 &&
               (s.ex_desti == s.id_rs || (s.id_uses_rt && s.ex_desti == s.id_rt));
    branch   = s.mem_pcsrc && m_mode != 3;
    e.fwd_a       = ref_fwd(s, s.ex_rs);
    e.fwd_b       = ref_fwd(s, s.ex_rt);
    e.hz_state    = 2'(m_mode);
    e.frz_ack     = (m_mode == 3);
    e.ifid_flush  = branch;
    e.exmem_flush = branch;
    e.idex_flush  = branch || (m_mode == 0 && load_use);
    e.pc_write    = !(m_mode == 3 || (m_mode == 0 && load_use && !branch));
    e.ifid_write  = e.pc_write;
    if (!s.rst) m_mode = 0;
    else if (m_mode == 0 && s.mem_pcsrc) m_mode = 2;
    else if (m_mode == 0 && load_use) m_mode = 1;
    else m_mode = s.frz_req ? 3 : 0;
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rt = s.id_uses_rt;
    ex_rs = s.ex_rs; ex_rt = s.ex_rt; ex_MemRead = s.ex_mem_read; ex_regDesti = s.ex_desti;
    mem_regWrite = s.mem_we; mem_regDesti = s.mem_desti; mem_PCSrc = s.mem_pcsrc;
    wb_regWrite = s.wb_we; wb_regDesti = s.wb_desti; frz_req = s.frz_req;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0b, expected %0b", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_write",    {1'b0, pc_write},    {1'b0, e.pc_write});
        chk("ifid_write",  {1'b0, ifid_write},  {1'b0, e.ifid_write});
        chk("ifid_flush",  {1'b0, ifid_flush},  {1'b0, e.ifid_flush});
        chk("idex_flush",  {1'b0, idex_flush},  {1'b0, e.idex_flush});
        chk("exmem_flush", {1'b0, exmem_flush}, {1'b0, e.exmem_flush});
        chk("fwd_a",       fwd_a,               e.fwd_a);
        chk("fwd_b",       fwd_b,               e.fwd_b);
        chk("hz_state",    hz_state,            e.hz_state);
        chk("frz_ack",     {1'b0, frz_ack},     {1'b0, e.frz_ack});
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rs = '0; ex_rt = '0;
    ex_MemRead = 1'b0; ex_regDesti = '0; mem_regWrite = 1'b0; mem_regDesti = '0;
    mem_PCSrc = 1'b0; wb_regWrite = 1'b0; wb_regDesti = '0; frz_req = 1'b0;
    apply(s);                                        // reset decode
    s = idle(); s.ex_rs = 3; s.mem_we = 1; s.mem_desti = 3; s.wb_we = 1; s.wb_desti = 3;
    apply(s);                                        // MEM beats WB
    s = idle(); s.ex_mem_read = 1; s.ex_desti = 2; s.id_rs = 2; s.id_rt = 2; s.id_uses_rt = 1;
    apply(s);                                        // load-use stall
    s = idle(); s.ex_rs = 2; s.ex_rt = 2; s.wb_we = 1; s.wb_desti = 2;
    s.ex_mem_read = 1; s.ex_desti = 2; s.id_rs = 2;  // ignored in LU_STALL
    apply(s);
    s = idle(); s.mem_pcsrc = 1; apply(s);           // taken branch
    apply(idle()); apply(idle());
    s = idle(); s.mem_pcsrc = 1; s.ex_mem_read = 1; s.ex_desti = 4; s.id_rs = 4; s.frz_req = 1;
    apply(s);                                        // branch beats lu and freeze
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.frz_req = 1; s.mem_pcsrc = (i == 2); apply(s);
    end
    apply(idle()); apply(idle());
    s = idle(); s.mem_we = 1; s.wb_we = 1; s.frz_req = 1; apply(s);  // $0 not forwarded
    s = idle(); s.frz_req = 1; apply(s);
    s = idle(); s.frz_req = 1; s.rst = 0; apply(s);  // reset in FREEZE
    apply(idle());
    s = idle(); s.ex_mem_read = 1; s.ex_desti = 1; s.id_rs = 1; apply(s);
    s = idle(); s.rst = 0; apply(s);                 // reset in LU_STALL
    apply(idle());

    for (int i = 0; i < 3000; i++) begin
      s.rst         = ($urandom_range(0, 59) != 0);
      s.id_rs       = REG_AW'($urandom_range(0, 3));
      s.id_rt       = REG_AW'($urandom_range(0, 3));
      s.id_uses_rt  = 1'($urandom_range(0, 1));
      s.ex_rs       = REG_AW'($urandom_range(0, 3));
      s.ex_rt       = REG_AW'($urandom_range(0, 3));
      s.ex_mem_read = ($urandom_range(0, 2) == 0);
      s.ex_desti    = REG_AW'($urandom_range(0, 3));
      s.mem_we      = 1'($urandom_range(0, 1));
      s.mem_desti   = REG_AW'($urandom_range(0, 3));
      s.mem_pcsrc   = ($urandom_range(0, 7) == 0);
      s.wb_we       = 1'($urandom_range(0, 1));
      s.wb_desti    = REG_AW'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) s.frz_req = ~s.frz_req;
      apply(s);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
